// File: rtl/sort_ctrl.sv
// Sequential bubble-sort controller: loads DEPTH words, sorts them in place with one
// shared ripple magnitude comparator (one compare/swap per clock), then streams them out.

module compare #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         g,
  output logic         l
);
  // Ripple from LSB upward: a higher bit that differs overrides the lower-bit verdict.
  logic [N:0] gc, lc;
  assign gc[0] = 1'b0;
  assign lc[0] = 1'b0;
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign gc[i+1] = (a[i] & ~b[i]) | (~(a[i] ^ b[i]) & gc[i]);
      assign lc[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & lc[i]);
    end
  endgenerate
  assign g = gc[N];
  assign l = lc[N];
endmodule

module sort_ctrl #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         desc,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] PEND = IW'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [DEPTH-1:0][N-1:0]  mem, mem_nxt;
  logic [IW-1:0]            idx, idx_nxt;
  logic [IW-1:0]            j, j_nxt, jp1;
  logic [IW-1:0]            pass_q, pass_nxt;
  logic                     swapped, swapped_nxt;
  logic                     desc_q, desc_nxt;
  logic                     cmp_g, cmp_l, do_swap;

  assign jp1 = j + IW'(1);

  compare #(.N(N)) u_cmp (
    .a (mem[j]),
    .b (mem[jp1]),
    .g (cmp_g),
    .l (cmp_l)
  );

  assign in_ready = (state == LOAD);
  assign busy     = (state == SORT);

  always_comb begin
    state_nxt   = state;
    mem_nxt     = mem;
    idx_nxt     = idx;
    j_nxt       = j;
    pass_nxt    = pass_q;
    swapped_nxt = swapped;
    desc_nxt    = desc_q;
    do_swap     = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          mem_nxt[idx] = in_data;
          if (idx == '0) desc_nxt = desc;
          if (idx == LAST) begin
            state_nxt   = SORT;
            idx_nxt     = '0;
            j_nxt       = '0;
            pass_nxt    = '0;
            swapped_nxt = 1'b0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      SORT: begin
        // Equal words never swap, which keeps the sort stable.
        do_swap = desc_q ? cmp_l : cmp_g;
        if (do_swap) begin
          mem_nxt[j]   = mem[jp1];
          mem_nxt[jp1] = mem[j];
        end
        if (j == PEND) begin
          if (!(swapped | do_swap) || pass_q == PEND) begin
            state_nxt = DRAIN;
            idx_nxt   = '0;
          end else begin
            pass_nxt    = pass_q + 1'b1;
            j_nxt       = '0;
            swapped_nxt = 1'b0;
          end
        end else begin
          j_nxt       = j + 1'b1;
          swapped_nxt = swapped | do_swap;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx == LAST) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
    // Abort wins over any handshake in the same cycle: nothing is written or latched.
    if (clear) begin
      state_nxt   = LOAD;
      mem_nxt     = mem;
      desc_nxt    = desc_q;
      idx_nxt     = '0;
      j_nxt       = '0;
      pass_nxt    = '0;
      swapped_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      mem       <= '0;
      idx       <= '0;
      j         <= '0;
      pass_q    <= '0;
      swapped   <= 1'b0;
      desc_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem       <= mem_nxt;
      idx       <= idx_nxt;
      j         <= j_nxt;
      pass_q    <= pass_nxt;
      swapped   <= swapped_nxt;
      desc_q    <= desc_nxt;
      // Output word is registered from the post-swap array so DRAIN starts with valid data.
      out_valid <= (state_nxt == DRAIN);
      out_data  <= (state_nxt == DRAIN) ? mem_nxt[idx_nxt] : '0;
      out_last  <= (state_nxt == DRAIN) && (idx_nxt == LAST);
    end
  end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequential sorting controller that loads DEPTH words of N bits and sorts them in place with odd/even-free bubble sort.
- Shares a single instance of the team's N-bit ripple magnitude comparator (compare) across all compare/swap steps, one comparison per clock.
- Streams the sorted result out.
- Sits between a ready/valid producer and consumer in the lab datapath as the sequencer for the compare block.

Parameters:
- N, 8, data word width; also the width of the internal compare instance.
- DEPTH, 4, number of words per sort batch; legal range is 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards the batch and returns to LOAD.
- desc  input  1  0 = ascending, 1 = descending; latched on the first load accept of a batch.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller accepts a word.
- in_data  input  N  input word.
- out_valid  output  1  sorted word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  N  sorted word.
- out_last  output  1  marks the final word of a batch.
- busy  output  1  high while sorting (SORT state).

Behaviour:
- Reset (async, rst=1):
  - state=LOAD; storage mem[0..DEPTH-1]=0; load/drain index=0; j=0; pass=0; swapped=0; mode latch=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Comparator use: A=mem[j], B=mem[j+1].
  - g=1 means A>B; l=1 means A<B; g=l=0 means equal.
  - Swap when (asc and g) or (desc and l). Equal never swaps, so the sort is stable.
- LOAD:
  - in_ready=1. Each in_valid&in_ready writes mem[idx] and increments idx.
  - desc is latched on the accept with idx=0.
  - On the accept with idx=DEPTH-1: next state is SORT, with j=0, pass=0, swapped=0.
- SORT:
  - busy=1, in_ready=0; in_valid is ignored.
  - Each cycle performs one compare/swap of mem[j] and mem[j+1]. Set swapped on any swap.
  - While j<DEPTH-2: j increments.
  - At j=DEPTH-2 (end of pass):
    - If (swapped=0 including this cycle's swap) or pass=DEPTH-2, go to DRAIN with idx=0.
    - Otherwise pass increments, j=0, swapped=0.
  - Cycle count: best case DEPTH-1 (already sorted); worst case (DEPTH-1)^2.
- DRAIN:
  - out_valid=1, out_data=mem[idx], out_last=(idx==DEPTH-1).
  - On out_valid&out_ready, idx increments.
  - The accept at idx=DEPTH-1 returns to LOAD with idx=0; out_valid drops the next cycle.
  - With out_ready=0, out_data and out_last hold stable.
- out_data, out_valid and out_last are registered.
  - First out_valid appears the cycle after the last SORT cycle.
  - The first in_ready of the next batch appears the cycle after the last drain accept.
- clear (any state): next state is LOAD; idx, j, pass and swapped reset; out_valid=0.
  - mem contents are don't-care and are overwritten by the next batch.
  - clear dominates in_valid and out_ready in the same cycle; nothing is accepted in that cycle.
- Mid-batch desc changes have no effect; only the latched value is used.
- No in-flight overlap: a new batch cannot load while draining.

Test Plan (N=8, DEPTH=4):
- Reverse order, asc: load 4,3,2,1, out_ready=1.
  - busy high for exactly 9 cycles (3 passes, no early exit).
  - Output is 1,2,3,4 with out_last only on 4; in_ready returns the cycle after.
- Presorted early exit, asc: load 1,2,3,4.
  - busy for exactly 3 cycles.
  - Output is 1,2,3,4.
- Descending with duplicates and extremes: desc=1 at first accept, load 0x05,0xFF,0x05,0x00.
  - Output is 0xFF,0x05,0x05,0x00.
  - Toggling desc during SORT has no effect.
- Backpressure: during DRAIN drive out_ready as the pattern 0,0,1,0,1,1,1.
  - out_data holds while stalled.
  - Each word is emitted exactly once, in order, and out_last is asserted together with the 4th word.
- Flow-control ignore: hold in_valid=1 with in_data=0xAA throughout SORT and DRAIN.
  - in_ready=0; no storage corruption; the output matches the loaded batch.
- Abort and reset:
  - clear asserted on the 2nd SORT cycle gives LOAD next cycle, with busy=0, out_valid=0, in_ready=1. A fresh batch 2,1,4,3 then sorts to 1,2,3,4.
  - rst asserted mid-DRAIN clears all outputs immediately, without waiting for a clock edge.
